// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
//   Byte-stream writer channel feeding the program loader.
//   in_valid : writer has a byte on in_data
//   in_ready : loader can take a byte this cycle
//   in_data  : byte value
//   A byte transfers on a rising clk edge where in_valid and in_ready are both 1.
//   Modports: master = byte writer, slave = prog_loader.
// -----------------------------------------------------------------------------
interface prog_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Writable 16 x `PROG_WIDTH program store for the minicpu, filled at run time
//   from a framed byte stream: HDR_BYTE, L (1..16), then L pairs {HI, LO} with
//   HI = {4'b0000, word[11:8]} and LO = word[7:0]; words land at 0..L-1.
//   The CPU is held (cpu_hold) while a load runs and after any failed load.
//
//   Optional feature: define PROG_LOADER_CHECKSUM_EN to require one trailing
//   checksum byte equal to -(L + sum of all HI/LO bytes) mod 256.
//
// Ports
//   clk          system clock, rising edge
//   n_reset      asynchronous active-low reset (memory back to FILL_WORD)
//   wr           byte-stream writer channel (slave side)
//   addr         CPU fetch address
//   out          mem[addr], combinational
//   cpu_hold     1 = CPU must stay in reset
//   load_done    one-cycle pulse on a successful load
//   load_err     one-cycle pulse on an aborted load
//   words_loaded word count of the last successful load
// -----------------------------------------------------------------------------
`ifndef PROG_WIDTH
`define PROG_WIDTH 12
`endif

module prog_loader #(
    parameter int                      ADDR_WIDTH = 4,
    parameter logic [`PROG_WIDTH-1:0]  FILL_WORD  = 12'b1111_0000_0000,
    parameter logic [7:0]              HDR_BYTE   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    n_reset,
    prog_loader_if.slave            wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    output logic [`PROG_WIDTH-1:0]  out,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    load_err,
    output logic [4:0]              words_loaded
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;   // must hold the value DEPTH itself

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FINISH,
        S_ABORT
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          len_q, len_d;
    logic [CNT_W-1:0]          ptr_q, ptr_d;
    logic [3:0]                nib_q, nib_d;
    logic [`PROG_WIDTH-1:0]    word_q, word_d;
    logic                      hold_q, hold_d;
    logic [4:0]                wl_q, wl_d;
    logic [`PROG_WIDTH-1:0]    mem_q [DEPTH];
    logic [`PROG_WIDTH-1:0]    mem_d [DEPTH];
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]                csum_q, csum_d;
`endif

    logic accept;
    assign accept = wr.in_valid && wr.in_ready;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            nib_q   <= '0;
            word_q  <= '0;
            hold_q  <= 1'b0;
            wl_q    <= '0;
            // NOTE: the store is flops, not a RAM macro, because reset must
            // restore defined contents (JMP 0) in every word, mid-load included.
            mem_q   <= '{default: FILL_WORD};
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking everywhere here so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            nib_q   <= nib_d;
            word_q  <= word_d;
            hold_q  <= hold_d;
            wl_q    <= wl_d;
            mem_q   <= mem_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned (that would infer a latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && wr.in_data == HDR_BYTE) state_d = S_LEN;
            S_LEN:   if (accept) state_d = (wr.in_data != 8'd0 && int'(wr.in_data) <= DEPTH)
                                           ? S_HI : S_ABORT;
            S_HI:    if (accept) state_d = (wr.in_data[7:4] == 4'd0) ? S_LO : S_ABORT;
            S_LO:    if (accept) state_d = S_WRITE;
            S_WRITE: begin
                if (ptr_q + CNT_W'(1) == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_FINISH;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            // The running sum plus a correct checksum byte wraps to zero.
            S_CSUM:  if (accept) state_d = (csum_q + wr.in_data == 8'd0) ? S_FINISH : S_ABORT;
`endif
            S_FINISH: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        wr.in_ready = n_reset && (state_q != S_WRITE);
        load_done   = (state_q == S_FINISH);
        load_err    = (state_q == S_ABORT);
    end

    assign cpu_hold     = hold_q;
    assign words_loaded = wl_q;
    assign out          = mem_q[addr];

    // ----------------------------------------------------------------- datapath
    always_comb begin
        len_d  = len_q;
        ptr_d  = ptr_q;
        nib_d  = nib_q;
        word_d = word_q;
        hold_d = hold_q;
        wl_d   = wl_q;
        mem_d  = mem_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d = csum_q;
`endif
        case (state_q)
            S_IDLE: if (accept && wr.in_data == HDR_BYTE) hold_d = 1'b1;
            S_LEN: if (accept) begin
                // Latched even when out of range; ABORT never uses it.
                len_d  = CNT_W'(wr.in_data);
                ptr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d = wr.in_data;
`endif
            end
            S_HI: if (accept) begin
                nib_d  = wr.in_data[3:0];
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d = csum_q + wr.in_data;
`endif
            end
            S_LO: if (accept) begin
                word_d = {nib_q, wr.in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d = csum_q + wr.in_data;
`endif
            end
            S_WRITE: begin
                mem_d[ptr_q[ADDR_WIDTH-1:0]] = word_q;
                ptr_d = ptr_q + CNT_W'(1);
            end
            // ABORT deliberately leaves hold_q set: the program is now partial.
            S_FINISH: begin
                wl_d   = 5'(len_q);
                hold_d = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Bench for prog_loader. A byte-level frame interpreter (position within the
//   frame, pending write, one terminal cycle) predicts every output each cycle;
//   directed frames pin the interpreter with literal expectations, then random
//   frames (good, bad length, bad nibble, bad checksum, junk, random gaps and
//   random fetch addresses) run against it.
// -----------------------------------------------------------------------------
`ifndef PROG_WIDTH
`define PROG_WIDTH 12
`endif

module tb_prog_loader;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   n_reset = 1'b0;
    logic [3:0]             addr = '0;
    logic [`PROG_WIDTH-1:0] out;
    logic                   cpu_hold, load_done, load_err;
    logic [4:0]             words_loaded;

    prog_loader_if wr ();

    prog_loader dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .wr          (wr),
        .addr        (addr),
        .out         (out),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ frame model
    int m_mem [16];
    bit m_hold;
    int m_wl;
    int pos;        // bytes consumed in the current frame, 0 = hunting for header
    int len, sum, hi, wptr, pend;
    bit stall;      // a word is being stored this cycle, no byte can be taken
    bit t_done, t_err;

    task model_reset();
        foreach (m_mem[i]) m_mem[i] = 'hF00;
        m_hold = 0; m_wl = 0; pos = 0; len = 0; sum = 0; hi = 0; wptr = 0;
        pend = 0; stall = 0; t_done = 0; t_err = 0;
    endtask

    task model_step(input logic v, input logic [7:0] b8);
        int b;
        b = b8;
        if (stall) begin
            m_mem[wptr] = pend;
            wptr++;
            stall = 0;
            if (wptr == len && !CSUM_EN) begin t_done = 1; pos = 0; end
        end else if (t_done) begin
            t_done = 0; m_hold = 0; m_wl = len;   // any byte offered now is lost
        end else if (t_err) begin
            t_err = 0;
        end else if (v) begin
            if (pos == 0) begin
                if (b == 'hA5) begin pos = 1; m_hold = 1; end
            end else if (pos == 1) begin
                if (b >= 1 && b <= 16) begin len = b; sum = b; wptr = 0; pos = 2; end
                else begin t_err = 1; pos = 0; end
            end else if (pos - 2 < 2 * len) begin
                if ((pos - 2) % 2 == 0) begin
                    if (b > 15) begin t_err = 1; pos = 0; end
                    else begin hi = b; sum += b; pos++; end
                end else begin
                    pend = hi * 256 + b; sum += b; stall = 1; pos++;
                end
            end else begin
                if (((sum + b) % 256) == 0) t_done = 1; else t_err = 1;
                pos = 0;
            end
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!n_reset) model_reset();
        check("in_ready", wr.in_ready, n_reset && !stall);
        check("cpu_hold", cpu_hold, m_hold);
        check("load_done", load_done, t_done);
        check("load_err", load_err, t_err);
        check("words_loaded", words_loaded, m_wl);
        check("out", out, m_mem[addr]);
        if (load_done === 1'b1) n_done++;
        if (load_err === 1'b1) n_err++;
        if (n_reset) model_step(wr.in_valid, wr.in_data);
    end

    // --------------------------------------------------------------- stimulus
    logic [7:0]             frame_q [$];
    logic [`PROG_WIDTH-1:0] words [16];

    task automatic idle(input int n);
        wr.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            addr = 4'($urandom);
            wr.in_data = 8'($urandom);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        wr.in_valid = 1'b1;
        wr.in_data  = b;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (wr.in_ready === 1'b1) begin
                @(posedge clk); #1;
                wr.in_valid = 1'b0;
                wr.in_data  = 8'($urandom);
                addr        = 4'($urandom);
                return;
            end
            @(posedge clk); #1;
            addr = 4'($urandom);
        end
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: byte %0h not taken within 32 cycles", b);
        wr.in_valid = 1'b0;
    endtask

    task automatic send_queue(input int gap);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic make_frame(input int n);
        logic [7:0] s;
        frame_q = {};
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        s = 8'(n);
        for (int i = 0; i < n; i++) begin
            words[i] = 12'($urandom);
            frame_q.push_back({4'h0, words[i][11:8]});
            frame_q.push_back(words[i][7:0]);
            s = s + {4'h0, words[i][11:8]} + words[i][7:0];
        end
        if (CSUM_EN) frame_q.push_back(8'(-s));
    endtask

    task automatic read_mem(input logic [3:0] a, input logic [11:0] exp);
        @(posedge clk); #1;
        addr = a;
        #1;
        check($sformatf("mem[%0d]", a), out, exp);
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, kind, gap, n;
        wr.in_valid = 1'b0;
        wr.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 n_reset = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("ready_after_reset", wr.in_ready, 1);
        check("hold_after_reset", cpu_hold, 0);
        check("wl_after_reset", words_loaded, 0);
        for (int a = 0; a < 16; a++) read_mem(4'(a), 12'hF00);

        // Good two-word load
        d0 = n_done;
        send_byte(8'hA5);
        #1 check("hold_after_hdr", cpu_hold, 1);
        frame_q = {8'h02, 8'h07, 8'h00, 8'h00, 8'h01};
        if (CSUM_EN) frame_q.push_back(8'hF6);
        send_queue(0);
        idle(3);
        check("done_pulses_good", n_done - d0, 1);
        check("wl_good", words_loaded, 2);
        check("hold_good", cpu_hold, 0);
        read_mem(0, 12'h700);
        read_mem(1, 12'h001);
        read_mem(2, 12'hF00);
        read_mem(15, 12'hF00);

        // Bad header nibble, then recovery
        e0 = n_err;
        frame_q = {8'hA5, 8'h01, 8'h17};
        send_queue(0);
        idle(3);
        check("err_pulses_nibble", n_err - e0, 1);
        check("hold_after_err", cpu_hold, 1);
        read_mem(0, 12'h700);
        frame_q = {8'hA5, 8'h01, 8'h0F, 8'h05};
        if (CSUM_EN) frame_q.push_back(8'hEB);
        send_queue(0);
        idle(3);
        read_mem(0, 12'hF05);
        read_mem(1, 12'h001);
        check("hold_recovered", cpu_hold, 0);
        check("wl_recovered", words_loaded, 1);

        // Length bounds
        e0 = n_err;
        frame_q = {8'hA5, 8'h00};
        send_queue(0);
        idle(3);
        check("err_len0", n_err - e0, 1);
        frame_q = {8'hA5, 8'h11};
        send_queue(0);
        idle(3);
        check("err_len17", n_err - e0, 2);
        check("hold_len_err", cpu_hold, 1);
        make_frame(16);
        send_queue(0);
        idle(3);
        check("wl_16", words_loaded, 16);
        check("hold_16", cpu_hold, 0);
        for (int a = 0; a < 16; a++) read_mem(4'(a), words[a]);

        // Junk and 3-cycle gaps between every byte
        d0 = n_done;
        send_byte(8'h00); idle(3);
        send_byte(8'hFF); idle(3);
        make_frame(3);
        send_queue(3);
        idle(3);
        check("done_gapped", n_done - d0, 1);
        check("wl_gapped", words_loaded, 3);
        for (int a = 0; a < 3; a++) read_mem(4'(a), words[a]);

        // Reset in the middle of a load
        e0 = n_err;
        make_frame(4);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i]);
        idle(2);
        read_mem(2, words[2]);
        @(posedge clk); #3 n_reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 n_reset = 1'b1;
        idle(2);
        check("hold_after_midreset", cpu_hold, 0);
        check("no_err_midreset", n_err - e0, 0);
        for (int a = 0; a < 16; a++) read_mem(4'(a), 12'hF00);

        // Random frames
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 9);
            gap  = $urandom_range(0, 2);
            n    = $urandom_range(1, 16);
            make_frame(n);
            if (kind == 6) begin
                frame_q = {8'hA5, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(17, 255))};
            end else if (kind == 7) begin
                frame_q[2 + 2 * $urandom_range(0, n - 1)] |= 8'(16 * $urandom_range(1, 15));
            end else if (kind == 8 && CSUM_EN) begin
                frame_q[frame_q.size() - 1] ^= 8'($urandom_range(1, 255));
            end else if (kind == 9) begin
                repeat ($urandom_range(1, 4)) frame_q.push_front(8'($urandom));
            end
            send_queue(gap);
            idle($urandom_range(0, 3));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writable program store for the minicpu: 16 words x `PROG_WIDTH (12) bits.
- Filled at run time from a byte-stream writer interface.
- Read side presents the same asynchronous addr/out view the CPU fetch path uses, so it drops in as the program source.
- Holds the CPU via cpu_hold while a load is in progress, and after any failed load.

Parameters:
- ADDR_WIDTH, 4: program address width; depth is 2**ADDR_WIDTH = 16.
- FILL_WORD, 12'b1111_00000000: reset contents of every word (JMP 0).
- HDR_BYTE, 8'hA5: byte that starts a load frame.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- in_valid  in  1  writer byte valid.
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid and in_ready are both 1 on a clk edge.
- in_data  in  8  writer byte.
- addr  in  ADDR_WIDTH  CPU fetch address.
- out  out  `PROG_WIDTH  instruction at addr; combinational, no latency.
- cpu_hold  out  1  1 = CPU must hold in reset.
- load_done  out  1  one-cycle pulse on successful load.
- load_err  out  1  one-cycle pulse on aborted load.
- words_loaded  out  5  word count of the last successful load (0..16).

Behaviour:
- Reset (async, n_reset=0):
  - All 16 words = FILL_WORD; state IDLE.
  - in_ready=0 while n_reset=0.
  - cpu_hold=0, load_done=0, load_err=0, words_loaded=0.
- Reset asserted mid-load aborts the load completely: memory returns to FILL_WORD; no load_err pulse.
- Frame format: HDR_BYTE, then L, then L pairs of {HI, LO}.
  - HI = {4'b0000, word[11:8]}; LO = word[7:0].
  - Words are written to addresses 0..L-1 in order.
- in_ready=1 in every state except WRITE.
- States:
  - IDLE:
    - Accepted byte == HDR_BYTE -> LEN; cpu_hold<=1 (visible next cycle).
    - Any other byte is discarded silently.
  - LEN:
    - Accepted byte with value 1..16 -> latch L, word pointer=0, go HI.
    - Value 0 or >16 -> ABORT.
  - HI:
    - Accepted byte with in_data[7:4]==0 -> latch nibble, go LO.
    - Otherwise -> ABORT.
  - LO: accepted byte -> assemble {nibble, byte}, go WRITE.
  - WRITE (1 cycle, in_ready=0):
    - mem[ptr]<=word; ptr<=ptr+1.
    - If ptr+1==L -> FINISH; else -> HI.
  - FINISH (1 cycle):
    - load_done=1; words_loaded<=L; cpu_hold<=0; -> IDLE.
  - ABORT (1 cycle):
    - load_err=1; cpu_hold stays 1 (sticky until a later successful load); -> IDLE.
    - Words already written keep their new values; unwritten words are unchanged.
- HDR_BYTE seen inside a frame is plain data; there is no resynchronisation.
- Idle cycles (in_valid=0) are allowed anywhere in a frame; there is no timeout.
- Read port:
  - out = mem[addr] combinationally at all times.
  - A word written at a clk edge is visible on out after that edge.
  - Addresses >= L keep their prior contents.
- Latency: header accept to cpu_hold=1 is 1 cycle. Last LO accept to load_done is 2 cycles (WRITE, FINISH).
- The pointer never wraps: L<=16 is enforced in LEN.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - A CSUM state follows the last WRITE instead of FINISH; one extra byte is expected there.
  - Required value: 8-bit two's-complement negation of the mod-256 sum of L and all HI/LO bytes.
  - Match -> FINISH. Mismatch -> ABORT.
  - Words are already written when the check runs; a mismatch therefore leaves cpu_hold=1.
- When undefined: no CSUM state; the frame ends after the last LO byte.

Test Plan:
- Reset check: reset, addr=0..15 -> out=12'hF00 everywhere; cpu_hold=0; in_ready=1 after reset release.
- Good load: bytes A5,02,07,00,00,01 (checksum build: append F6)
  - -> mem[0]=12'h700, mem[1]=12'h001, mem[2..15]=12'hF00.
  - load_done pulses once; words_loaded=2.
  - cpu_hold is 1 from the cycle after A5 through FINISH, then 0.
- Bad header nibble: A5,01,17 -> load_err pulse; cpu_hold stays 1; mem unchanged.
  - A following good frame A5,01,0F,05 (checksum build: append EB) -> mem[0]=12'hF05, cpu_hold=0.
- Length bounds: A5,00 -> load_err; A5,11 -> load_err; A5,10 then 16 pairs -> all 16 words written, words_loaded=16.
- Garbage and stalls: bytes 00,FF,A5 preceded by junk, with in_valid gapped 3 cycles between every byte -> junk ignored, load completes correctly.
  - in_ready=0 exactly in WRITE cycles.
  - Bytes presented during WRITE are held by the writer and accepted the next cycle.
- Mid-load reset: assert n_reset after the 3rd word -> all words return to F00; cpu_hold=0; no load_err pulse.
